// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: PC generation, fixed 1-cycle i_mem access,
// and a small first-word-fall-through FIFO feeding ID over valid/ready.
// A taken branch from EX redirects fetch and discards everything buffered
// or in flight.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       ex_if_take_branch,
  input  logic [31:0]                ex_if_branch_target,
  input  logic                       id_ready,
  output logic                       if_id_valid,
  output logic [31:0]                if_id_pc,
  output logic [31:0]                if_id_instr_data,
  output logic [$clog2(DEPTH+1)-1:0] if_occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OCC_W:0] DEPTH_EXT = (OCC_W + 1)'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic             rsp_pending_q;
  logic [31:0]      rsp_pc_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]      mem_pc_q   [DEPTH];
  logic [31:0]      mem_instr_q[DEPTH];

  logic             pop;
  logic             push;
  logic [OCC_W:0]   committed;

  // Issue decision, fetch address and FIFO bookkeeping for this cycle.
  always_comb begin
    pop       = if_id_valid & id_ready;
    // A flush drops the arriving response, so nothing is pushed on a branch.
    push      = rsp_pending_q & ~ex_if_take_branch;
    // Entries held plus the one in flight, minus what ID takes now; only
    // issue when the response is guaranteed a free slot.
    committed = {1'b0, occ_q} + {{OCC_W{1'b0}}, rsp_pending_q} - {{OCC_W{1'b0}}, pop};
    imem_req  = rst & (ex_if_take_branch | (committed < DEPTH_EXT));
    imem_addr = ex_if_take_branch ? {ex_if_branch_target[31:2], 2'b00} : pc_q;

    pc_d      = imem_req ? (imem_addr + 32'd4) : pc_q;
    occ_d     = occ_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (ex_if_take_branch) begin
      occ_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Control state: PC, response tracking and FIFO pointers/occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      rsp_pending_q <= 1'b0;
      rsp_pc_q      <= '0;
      occ_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pending_q <= imem_req;
      rsp_pc_q      <= imem_addr;
      occ_q         <= occ_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // FIFO storage: one register pair per entry, written when the pending
  // response lands in that slot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mem_pc_q[gi]    <= '0;
        mem_instr_q[gi] <= '0;
      end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
        mem_pc_q[gi]    <= rsp_pc_q;
        mem_instr_q[gi] <= imem_rdata;
      end
    end
  end

  // Head entry is read straight from registers, so it is stable while stalled.
  always_comb begin
    if_id_valid      = (occ_q != '0);
    if_id_pc         = mem_pc_q[rd_ptr_q];
    if_id_instr_data = mem_instr_q[rd_ptr_q];
    if_occupancy     = occ_q;
  end

endmodule
